// File: rtl/debug_scan_tx.sv
// debug_scan_tx: host-side debug sweeper that steps/halts the core and streams a framed byte dump of all debug words
// Ports: clk; rst (async, active-low); halt/start/step_req control; debug_en, debug_step, debug_addr, debug_data core debug port;
//        tx_data/tx_valid/tx_ready byte stream; busy and frame_cnt status.
// Option: `define DEBUG_SCAN_CHECKSUM_EN appends one XOR-of-frame byte after the last data byte.
module debug_scan_tx #(
  parameter int NUM_WORDS = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        start,
  input  logic        step_req,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  frame_cnt
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [3:0] {IDLE, STEP, SETTLE, HDR, ADDR, CAP, SEND, CSUM, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] idx;
  logic [31:0] word;
  logic [1:0] bsel;
  logic xfer;
  logic [7:0] idx_n;
  assign xfer = tx_valid & tx_ready;
  assign idx_n = idx + 8'd1;
`ifdef DEBUG_SCAN_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst)
    if (!rst) csum <= '0;
    else if (state == IDLE) csum <= '0;
    else if (xfer) csum <= csum ^ tx_data;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      word <= '0;
      bsel <= '0;
      debug_en <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= '0;
    end else begin
      debug_en <= halt;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          cnt <= '0;
          bsel <= '0;
          if (step_req && debug_en) begin
            state <= STEP;
            debug_step <= 1'b1;
          end else begin
            state <= HDR;
            tx_valid <= 1'b1;
            tx_data <= HEADER;
          end
        end
        STEP: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state <= SETTLE;
          debug_step <= 1'b0;
          cnt <= '0;
        end else cnt <= cnt + CW'(1);
        SETTLE: if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state <= HDR;
          tx_valid <= 1'b1;
          tx_data <= HEADER;
        end else cnt <= cnt + CW'(1);
        HDR: if (xfer) begin
          if (bsel[0]) begin
            state <= ADDR;
            tx_valid <= 1'b0;
            debug_addr <= idx[6:0];
          end else tx_data <= frame_cnt;
          bsel <= bsel + 2'd1;
        end
        ADDR: state <= CAP;
        CAP: begin
          state <= SEND;
          word <= debug_data;
          tx_data <= debug_data[7:0];
          tx_valid <= 1'b1;
          bsel <= '0;
        end
        SEND: if (xfer) begin
          word <= {8'h00, word[31:8]};
          tx_data <= word[15:8];
          bsel <= bsel + 2'd1;
          if (bsel == 2'd3) begin
            idx <= idx_n;
            tx_valid <= 1'b0;
            if (idx_n == 8'(NUM_WORDS)) begin
`ifdef DEBUG_SCAN_CHECKSUM_EN
              state <= CSUM;
              tx_valid <= 1'b1;
              tx_data <= csum ^ tx_data;
`else
              state <= DONE;
`endif
            end else begin
              state <= ADDR;
              debug_addr <= idx_n[6:0];
            end
          end
        end
        CSUM: if (xfer) begin
          state <= DONE;
          tx_valid <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          frame_cnt <= frame_cnt + 8'd1;
          busy <= 1'b0;
          idx <= '0;
          debug_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/debug_scan_tx.md
Name: debug_scan_tx

Overview:
- Host-side partner of the core's debug port.
- Drives debug_en, debug_step and debug_addr; reads debug_data; streams a framed byte dump of all debug words over a valid/ready byte interface.
- The byte stream feeds the board UART/console path.
- Sits beside RV32core at top level; replaces manual switch-driven register inspection.

Parameters:
- NUM_WORDS, 64, number of debug words swept per frame (addresses 0..NUM_WORDS-1; 0-31 regs, 32-63 test signals); legal range 1..128.
- SETTLE_CYCLES, 4, cycles debug_step is held high, then low, around one step; minimum 1.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- halt  input  1  request core into debug mode
- start  input  1  one-cycle pulse: begin a frame
- step_req  input  1  sampled with start: 1 = single-step the core before sweeping
- debug_en  output  1  to core debug_en
- debug_step  output  1  to core debug_step
- debug_addr  output  7  to core debug_addr
- debug_data  input  32  from core debug_data
- tx_data  output  8  stream byte
- tx_valid  output  1  stream byte valid
- tx_ready  input  1  sink accepts byte
- busy  output  1  frame in progress
- frame_cnt  output  8  frames completed, wraps 255->0

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs immediately to 0: debug_en, debug_step, debug_addr, tx_data, tx_valid, busy, frame_cnt. State returns to IDLE. A frame in progress is abandoned with no partial resume.
- debug_en is halt registered once (one cycle latency), independent of FSM state.
- States and transitions:
  - IDLE: on start, busy=1 next cycle; go to STEP if step_req & debug_en, else HDR. start is ignored while busy=1.
  - STEP: debug_step=1 for SETTLE_CYCLES cycles, then SETTLE.
  - SETTLE: debug_step=0 for SETTLE_CYCLES cycles, then HDR.
  - HDR: present HEADER, then frame_cnt, one byte per handshake.
  - ADDR: debug_addr=idx for one cycle.
  - CAP: latch debug_data into a 32-bit word register; go to SEND.
  - SEND: emit the word as 4 bytes, LSB first. After byte 3, idx++; if idx==NUM_WORDS go to DONE, else ADDR.
  - DONE: frame_cnt++, busy=0, idx=0, debug_addr=0, return to IDLE.
- Handshake:
  - A byte transfers on the cycle where tx_valid & tx_ready are both 1.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high.
  - tx_valid never drops without a transfer except on reset.
  - Back-to-back transfers sustain 1 byte/cycle within a word. ADDR+CAP add 2 bubble cycles between words.
- debug_addr holds its value from ADDR through SEND; the core sees a stable address.
- Frame length is 2 + 4*NUM_WORDS bytes (258 by default).
- frame_cnt sent in the header is the pre-increment value.
- idx counter is wide enough for NUM_WORDS (8 bits); no wrap inside a frame.
- Halt dropped mid-frame: the sweep continues; debug_en follows halt. A STEP already started completes its full high/low timing.
- step_req with debug_en=0: the step is skipped and the frame starts directly at HDR.

Optional Feature:
- Macro DEBUG_SCAN_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent before DONE. It is the XOR of all preceding frame bytes, header and frame_cnt included. Frame length becomes 3 + 4*NUM_WORDS.
- Undefined: no checksum byte, and no checksum logic is synthesised.

Test Plan:
- Reset, halt=1, start, step_req=0, tx_ready=1, stub debug_data = {25'h0, debug_addr} -> bytes A5,00, then 00,00,00,00, 01,00,00,00 ... 3F,00,00,00; 258 bytes; busy falls; frame_cnt=1.
- halt=1, start with step_req=1, SETTLE_CYCLES=4 -> debug_step high exactly 4 cycles, low 4 cycles, then header A5; stub core step counter = 1.
- tx_ready toggles 1,0,0,1 pseudo-randomly with debug_data=32'hDEADBEEF -> each word arrives as EF,BE,AD,DE; tx_data stable during every stall; no byte lost or duplicated.
- Second start pulse mid-frame -> ignored; frame still 258 bytes. Then 256 frames run -> frame_cnt wraps to 0 and header byte 2 of frame 257 = 00.
- rst driven low during SEND of word 10 -> tx_valid, busy, debug_addr = 0 asynchronously. After release, a new start produces a complete frame beginning A5, 00.
- With DEBUG_SCAN_CHECKSUM_EN, all-zero debug_data, frame_cnt=0 -> 259 bytes, last byte = A5.
